aes_key_expander: RTL and testbench

AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

---
 rtl/aes_key_expander.sv | 94 +++++++++
 tb/tb_aes_key_expander.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES key schedule, one 32-bit word per clock, NK = 4/6/8.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset; clears FSM, counters and all stored words
//   start      - expand key_in; accepted only while idle
//   key_in     - NK*32-bit cipher key, w[0] in the most significant word
//   busy       - high while expanding or signalling completion
//   done       - one-cycle pulse when the schedule is complete
//   keys_valid - stored schedule is complete and belongs to the last accepted key
//   rk_idx     - round-key select, 0..NR
//   rk_out     - round key rk_idx (zero when keys are not valid or rk_idx > NR)
module aes_key_expander #(
   parameter int NK = 4,
   parameter int NR = NK + 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NK*32-1:0] key_in,
   output logic             busy,
   output logic             done,
   output logic             keys_valid,
   input  logic [3:0]       rk_idx,
   output logic [127:0]     rk_out
);
   localparam int TW = 4 * (NR + 1);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
   state_t      state, state_nx;
   logic [31:0] w [TW];
   logic [5:0]  i;
   logic [3:0]  j;      // i mod NK, tracked incrementally to avoid a divider
   logic [7:0]  rcon;   // Rcon[i/NK], advanced by xtime after each use
   logic [31:0] prev, sub_in, sub_out, temp, new_word;
   logic [5:0]  base;
   logic        last;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   assign prev     = w[i - 6'd1];
   assign sub_in   = (j == 4'd0) ? {prev[23:0], prev[31:24]} : prev;
   assign sub_out  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
   assign temp     = (j == 4'd0) ? (sub_out ^ {rcon, 24'h0}) : (NK == 8 && j == 4'd4) ? sub_out : prev;
   assign new_word = w[i - 6'(NK)] ^ temp;
   assign last     = (i == 6'(TW - 1));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_comb begin
      state_nx = IDLE;
      state_nx = (state == IDLE)   ? (start ? EXPAND : IDLE) :
                 (state == EXPAND) ? (last ? DONE : EXPAND)  : IDLE;
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         i          <= '0;
         j          <= '0;
         rcon       <= 8'h01;
         keys_valid <= 1'b0;
         for (int k = 0; k < TW; k++) w[k] <= '0;
      end else if (state == IDLE && start) begin
         for (int k = 0; k < NK; k++) w[k] <= key_in[(NK-1-k)*32 +: 32];
         i          <= 6'(NK);
         j          <= '0;
         rcon       <= 8'h01;
         keys_valid <= 1'b0;
      end else if (state == EXPAND) begin
         w[i] <= new_word;
         i    <= i + 6'd1;
         j    <= (j == 4'(NK - 1)) ? 4'd0 : j + 4'd1;
         if (j == 4'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
         if (last) keys_valid <= 1'b1;
      end

   assign base   = {rk_idx, 2'b00};
   assign rk_out = (keys_valid && rk_idx <= 4'(NR)) ?
                   {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;
endmodule

// File: tb/tb_aes_key_expander.sv
// tb_aes_key_expander: scoreboard bench for aes_key_expander at NK = 4, 6 and 8.
module tb_aes_key_expander;
   localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] F_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] F_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K_SEQ4 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] S_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [191:0] K_SEQ6 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [127:0] S6_RK12 = 128'ha4970a331a78dc09c418c271e3a41d5d;
   localparam logic [255:0] K_SEQ8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] S8_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         st [3];
   logic [3:0]   idx [3];
   logic         busy_s [3], done_s [3], kv_s [3];
   logic [127:0] rk_s [3];
   logic [127:0] key4 = '0;
   logic [191:0] key6 = '0;
   logic [255:0] key8 = '0;

   typedef struct {int s; logic [3:0] idx; logic [127:0] v;} exp_t;
   exp_t sbq [$];
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   aes_key_expander #(.NK(4)) d4 (.clk(clk), .rst_n(rst_n), .start(st[0]), .key_in(key4),
      .busy(busy_s[0]), .done(done_s[0]), .keys_valid(kv_s[0]), .rk_idx(idx[0]), .rk_out(rk_s[0]));
   aes_key_expander #(.NK(6)) d6 (.clk(clk), .rst_n(rst_n), .start(st[1]), .key_in(key6),
      .busy(busy_s[1]), .done(done_s[1]), .keys_valid(kv_s[1]), .rk_idx(idx[1]), .rk_out(rk_s[1]));
   aes_key_expander #(.NK(8)) d8 (.clk(clk), .rst_n(rst_n), .start(st[2]), .key_in(key8),
      .busy(busy_s[2]), .done(done_s[2]), .keys_valid(kv_s[2]), .rk_idx(idx[2]), .rk_out(rk_s[2]));

   task automatic push(input int s, input logic [3:0] i, input logic [127:0] v);
      exp_t e;
      e.s = s;
      e.idx = i;
      e.v = v;
      sbq.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         idx[e.s] = e.idx;
         #1;
         checks++;
         if (rk_s[e.s] !== e.v) begin
            failures++;
            $display("FAIL rk nk%0d idx=%0d got=%h exp=%h", 4 + 2*e.s, e.idx, rk_s[e.s], e.v);
         end
      end
      for (int s = 0; s < 3; s++) idx[s] = 4'd0;
   endtask

   // Leaves the caller at the negedge of cycle 1 (first cycle after the start edge).
   task automatic start_exp(input int s, input logic [255:0] k);
      @(negedge clk);
      case (s)
         0:       key4 = k[127:0];
         1:       key6 = k[191:0];
         default: key8 = k;
      endcase
      st[s] = 1'b1;
      @(negedge clk);
      st[s] = 1'b0;
   endtask

   task automatic wait_done(input int s, input int cyc0, output int cyc);
      cyc = cyc0;
      while (done_s[s] !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_expand(input int s, input logic [255:0] k, input int exp_cyc);
      int cyc;
      start_exp(s, k);
      checks++;
      if ({busy_s[s], kv_s[s], done_s[s]} !== 3'b100) begin
         failures++;
         $display("FAIL start_flags nk%0d got busy/kv/done=%b exp 100", 4 + 2*s, {busy_s[s], kv_s[s], done_s[s]});
      end
      checks++;
      if (rk_s[s] !== '0) begin
         failures++;
         $display("FAIL rk_masked nk%0d got=%h exp=0", 4 + 2*s, rk_s[s]);
      end
      wait_done(s, 1, cyc);
      checks++;
      if (done_s[s] !== 1'b1 || cyc != exp_cyc) begin
         failures++;
         $display("FAIL done_latency nk%0d got cycle %0d done=%b exp cycle %0d", 4 + 2*s, cyc, done_s[s], exp_cyc);
      end
      checks++;
      if ({busy_s[s], kv_s[s]} !== 2'b11) begin
         failures++;
         $display("FAIL done_flags nk%0d got busy/kv=%b exp 11", 4 + 2*s, {busy_s[s], kv_s[s]});
      end
      @(negedge clk);
      checks++;
      if ({done_s[s], busy_s[s], kv_s[s]} !== 3'b001) begin
         failures++;
         $display("FAIL after_done nk%0d got done/busy/kv=%b exp 001", 4 + 2*s, {done_s[s], busy_s[s], kv_s[s]});
      end
      drain();
   endtask

   task automatic test_reset();
      #2;
      for (int s = 0; s < 3; s++) begin
         checks++;
         if ({busy_s[s], done_s[s], kv_s[s]} !== 3'b000 || rk_s[s] !== '0) begin
            failures++;
            $display("FAIL reset nk%0d got busy/done/kv=%b rk=%h exp 000 rk=0", 4 + 2*s,
                     {busy_s[s], done_s[s], kv_s[s]}, rk_s[s]);
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fips_nk4();
      push(0, 4'd0, K_FIPS);
      push(0, 4'd1, F_RK1);
      push(0, 4'd10, F_RK10);
      push(0, 4'd11, '0);
      push(0, 4'd15, '0);
      test_expand(0, {128'h0, K_FIPS}, 41);
   endtask

   task automatic test_restart_nk4();
      checks++;
      if (kv_s[0] !== 1'b1) begin
         failures++;
         $display("FAIL restart_pre_kv got=%b exp=1", kv_s[0]);
      end
      push(0, 4'd10, S_RK10);
      push(0, 4'd0, K_SEQ4);
      test_expand(0, {128'h0, K_SEQ4}, 41);
   endtask

   task automatic test_nk6();
      push(1, 4'd12, S6_RK12);
      push(1, 4'd0, K_SEQ6[191:64]);
      push(1, 4'd13, '0);
      test_expand(1, {64'h0, K_SEQ6}, 47);
   endtask

   task automatic test_nk8();
      push(2, 4'd14, S8_RK14);
      push(2, 4'd0, K_SEQ8[255:128]);
      push(2, 4'd1, K_SEQ8[127:0]);
      push(2, 4'd15, '0);
      test_expand(2, K_SEQ8, 53);
   endtask

   task automatic test_ignore_start();
      int cyc;
      int pulses;
      push(0, 4'd0, K_FIPS);
      push(0, 4'd1, F_RK1);
      push(0, 4'd10, F_RK10);
      start_exp(0, {128'h0, K_FIPS});
      key4 = K_SEQ4;
      repeat (9) @(negedge clk);
      st[0] = 1'b1;
      key4 = ~K_FIPS;
      @(negedge clk);
      st[0] = 1'b0;
      wait_done(0, 11, cyc);
      checks++;
      if (done_s[0] !== 1'b1 || cyc != 41) begin
         failures++;
         $display("FAIL ignore_latency got cycle %0d done=%b exp cycle 41", cyc, done_s[0]);
      end
      pulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (done_s[0] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL ignore_extra_done got=%0d exp=0", pulses);
      end
      drain();
   endtask

   task automatic test_reset_abort();
      int pulses;
      start_exp(0, {128'h0, K_SEQ4});
      repeat (19) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy_s[0], done_s[0], kv_s[0]} !== 3'b000 || rk_s[0] !== '0) begin
         failures++;
         $display("FAIL abort_nk4 got busy/done/kv=%b rk=%h exp 000 rk=0", {busy_s[0], done_s[0], kv_s[0]}, rk_s[0]);
      end
      checks++;
      if ({kv_s[1], kv_s[2]} !== 2'b00 || rk_s[1] !== '0 || rk_s[2] !== '0) begin
         failures++;
         $display("FAIL abort_others got kv6/kv8=%b rk6=%h rk8=%h exp 00 and 0", {kv_s[1], kv_s[2]}, rk_s[1], rk_s[2]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (60) begin
         @(negedge clk);
         if (done_s[0] === 1'b1 || busy_s[0] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || kv_s[0] !== 1'b0) begin
         failures++;
         $display("FAIL abort_quiet got activity=%0d kv=%b exp 0 and 0", pulses, kv_s[0]);
      end
      push(0, 4'd1, F_RK1);
      push(0, 4'd10, F_RK10);
      test_expand(0, {128'h0, K_FIPS}, 41);
   endtask

   initial begin
      for (int s = 0; s < 3; s++) begin
         st[s] = 1'b0;
         idx[s] = 4'd0;
      end
      test_reset();
      test_fips_nk4();
      test_restart_nk4();
      test_nk6();
      test_nk8();
      test_ignore_start();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
